// File: rtl/tamarisc_pkg.sv
// Shared definitions for the tamarisc fetch front end.
//   fetch_state_e       : fetch controller FSM encoding
//   FLUSH_DEPTH_DEFAULT : default number of flush cycles after a taken branch
package tamarisc_pkg;

    localparam int unsigned FLUSH_DEPTH_DEFAULT = 2;

    typedef enum logic [2:0] {
        StBoot,
        StFetch,
        StWaitMem,
        StFlush,
        StHalt
    } fetch_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Ports:
//   clk   : clock, rising edge
//   rst   : asynchronous active-high reset, count -> 0
//   inc   : increment request (ignored once count is all-ones)
//   clr   : synchronous clear, takes priority over inc
//   count : current count value
module sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: sequences PC control and instruction memory
// requests around memory waits, taken branches, load-use stalls and halt.
// Ports:
//   clk_i          : clock, rising edge
//   rst_i          : asynchronous active-high reset
//   imem_ack_i     : instruction memory returns a valid word this cycle
//   branch_taken_i : execute resolved a taken branch; target on arith path
//   load_use_i     : decode detected a load-use hazard
//   halt_i         : halt request
//   resume_i       : leave halt
//   cnt_clr_i      : synchronous clear of the stall counter
//   imem_req_o     : fetch request to instruction memory
//   stall_o        : PC stall
//   incr_pc_o      : PC increment
//   load_arith_o   : PC load from arith path
//   flush_o        : kill instructions in decode/execute
//   halted_o       : controller is halted
//   stall_cnt_o    : saturating count of cycles with stall_o high
module fetch_ctrl
    import tamarisc_pkg::*;
#(
    parameter int unsigned FLUSH_DEPTH = FLUSH_DEPTH_DEFAULT,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             imem_ack_i,
    input  logic             branch_taken_i,
    input  logic             load_use_i,
    input  logic             halt_i,
    input  logic             resume_i,
    input  logic             cnt_clr_i,
    output logic             imem_req_o,
    output logic             stall_o,
    output logic             incr_pc_o,
    output logic             load_arith_o,
    output logic             flush_o,
    output logic             halted_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    // The branch cycle itself is the first flush cycle, so FLUSH lasts one less.
    localparam logic [1:0] FlushLoad = 2'(FLUSH_DEPTH - 1);

    fetch_state_e state_q, state_d;
    logic         drop_ack_q, drop_ack_d;
    logic [1:0]   flush_cnt_q, flush_cnt_d;
    logic         eff_ack;

    // An ack belonging to a fetch abandoned by a branch must not advance the PC.
    assign eff_ack = imem_ack_i & ~drop_ack_q;

    always_comb begin
        state_d      = state_q;
        drop_ack_d   = drop_ack_q;
        flush_cnt_d  = flush_cnt_q;
        imem_req_o   = 1'b0;
        stall_o      = 1'b0;
        incr_pc_o    = 1'b0;
        load_arith_o = 1'b0;
        flush_o      = 1'b0;
        halted_o     = 1'b0;

        if (imem_ack_i) begin
            drop_ack_d = 1'b0;
        end

        if (state_q == StHalt) begin
            stall_o  = 1'b1;
            halted_o = 1'b1;
            if (resume_i) begin
                state_d = StFetch;
            end
        end else begin
            imem_req_o = (state_q != StBoot);
            if (branch_taken_i) begin
                load_arith_o = 1'b1;
                flush_o      = 1'b1;
                flush_cnt_d  = FlushLoad;
                state_d      = (FLUSH_DEPTH > 1) ? StFlush : StFetch;
                // Only an outstanding (not yet acked) request leaves a stale ack behind.
                if ((state_q == StWaitMem) && !imem_ack_i) begin
                    drop_ack_d = 1'b1;
                end
            end else if (halt_i) begin
                stall_o = 1'b1;
                flush_o = (state_q == StFlush);
                state_d = StHalt;
            end else begin
                unique case (state_q)
                    StBoot: begin
                        stall_o = 1'b1;
                        state_d = StFetch;
                    end
                    StFetch: begin
                        if (load_use_i) begin
                            stall_o = 1'b1;
                        end else if (!eff_ack) begin
                            stall_o = 1'b1;
                            state_d = StWaitMem;
                        end else begin
                            incr_pc_o = 1'b1;
                        end
                    end
                    StWaitMem: begin
                        if (load_use_i) begin
                            stall_o = 1'b1;
                        end else if (eff_ack) begin
                            incr_pc_o = 1'b1;
                            state_d   = StFetch;
                        end else begin
                            stall_o = 1'b1;
                        end
                    end
                    StFlush: begin
                        // Decode is being killed, so a load-use hazard there is moot.
                        flush_o     = 1'b1;
                        incr_pc_o   = eff_ack;
                        flush_cnt_d = flush_cnt_q - 2'd1;
                        if (flush_cnt_q <= 2'd1) begin
                            state_d = StFetch;
                        end
                    end
                    default: begin
                        stall_o = 1'b1;
                        state_d = StBoot;
                    end
                endcase
            end
        end

        // Outputs are held quiet for the whole reset window, whatever the inputs.
        if (rst_i) begin
            imem_req_o   = 1'b0;
            stall_o      = 1'b1;
            incr_pc_o    = 1'b0;
            load_arith_o = 1'b0;
            flush_o      = 1'b0;
            halted_o     = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= StBoot;
            drop_ack_q  <= 1'b0;
            flush_cnt_q <= 2'd0;
        end else begin
            state_q     <= state_d;
            drop_ack_q  <= drop_ack_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_stall_cnt (
        .clk   (clk_i),
        .rst   (rst_i),
        .inc   (stall_o),
        .clr   (cnt_clr_i),
        .count (stall_cnt_o)
    );

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed self-checking bench for fetch_ctrl (FLUSH_DEPTH=2), with a second
// CNT_W=4 instance sharing the stimulus to exercise counter saturation.
module tb_fetch_ctrl;

    logic clk = 1'b0;
    logic rst, ack, branch, load_use, halt, resume, cnt_clr;

    logic        imem_req, stall, incr, load_arith, flush, halted;
    logic [15:0] cnt;
    logic        imem_req4, stall4, incr4, load_arith4, flush4, halted4;
    logic [3:0]  cnt4;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fetch_ctrl #(
        .FLUSH_DEPTH (2),
        .CNT_W       (16)
    ) u_dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .imem_ack_i     (ack),
        .branch_taken_i (branch),
        .load_use_i     (load_use),
        .halt_i         (halt),
        .resume_i       (resume),
        .cnt_clr_i      (cnt_clr),
        .imem_req_o     (imem_req),
        .stall_o        (stall),
        .incr_pc_o      (incr),
        .load_arith_o   (load_arith),
        .flush_o        (flush),
        .halted_o       (halted),
        .stall_cnt_o    (cnt)
    );

    fetch_ctrl #(
        .FLUSH_DEPTH (2),
        .CNT_W       (4)
    ) u_dut4 (
        .clk_i          (clk),
        .rst_i          (rst),
        .imem_ack_i     (ack),
        .branch_taken_i (branch),
        .load_use_i     (load_use),
        .halt_i         (halt),
        .resume_i       (resume),
        .cnt_clr_i      (cnt_clr),
        .imem_req_o     (imem_req4),
        .stall_o        (stall4),
        .incr_pc_o      (incr4),
        .load_arith_o   (load_arith4),
        .flush_o        (flush4),
        .halted_o       (halted4),
        .stall_cnt_o    (cnt4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Inputs change just after the falling edge; outputs are checked 1 time unit later.
    task automatic cyc;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; ack = 1'b1; branch = 1'b1; load_use = 1'b0;
        halt = 1'b0; resume = 1'b0; cnt_clr = 1'b0;

        // Reset: outputs quiet even with a branch request present
        cyc; #1;
        chk("rst_req",        32'(imem_req),    32'd0);
        chk("rst_stall",      32'(stall),       32'd1);
        chk("rst_incr",       32'(incr),        32'd0);
        chk("rst_load_arith", 32'(load_arith),  32'd0);
        chk("rst_flush",      32'(flush),       32'd0);
        chk("rst_halted",     32'(halted),      32'd0);
        chk("rst_cnt",        32'(cnt),         32'd0);
        chk("rst4_req",       32'(imem_req4),   32'd0);
        chk("rst4_stall",     32'(stall4),      32'd1);
        chk("rst4_incr",      32'(incr4),       32'd0);
        chk("rst4_la",        32'(load_arith4), 32'd0);
        chk("rst4_flush",     32'(flush4),      32'd0);
        chk("rst4_halted",    32'(halted4),     32'd0);
        chk("rst4_cnt",       32'(cnt4),        32'd0);
        branch = 1'b0;

        // Release with ack held: one BOOT stall cycle, then increments
        cyc; rst = 1'b0; #1;
        chk("boot_stall", 32'(stall),    32'd1);
        chk("boot_req",   32'(imem_req), 32'd0);
        chk("boot_incr",  32'(incr),     32'd0);
        cyc; #1;
        chk("fetch_incr",  32'(incr),     32'd1);
        chk("fetch_stall", 32'(stall),    32'd0);
        chk("fetch_req",   32'(imem_req), 32'd1);
        chk("fetch_cnt",   32'(cnt),      32'd1);
        cyc; #1;
        chk("fetch2_incr", 32'(incr), 32'd1);
        chk("fetch2_cnt",  32'(cnt),  32'd1);

        // Ack missing for 3 cycles
        cyc; ack = 1'b0; #1;
        chk("miss1_stall", 32'(stall), 32'd1);
        chk("miss1_incr",  32'(incr),  32'd0);
        cyc; #1;
        chk("miss2_stall", 32'(stall), 32'd1);
        cyc; #1;
        chk("miss3_stall", 32'(stall), 32'd1);
        cyc; ack = 1'b1; #1;
        chk("ack_incr",  32'(incr),  32'd1);
        chk("ack_stall", 32'(stall), 32'd0);
        chk("ack_cnt",   32'(cnt),   32'd4);
        cyc; #1;
        chk("post_ack_incr", 32'(incr), 32'd1);

        // Branch in FETCH
        cyc; branch = 1'b1; #1;
        chk("br_load_arith", 32'(load_arith), 32'd1);
        chk("br_flush",      32'(flush),      32'd1);
        chk("br_incr",       32'(incr),       32'd0);
        chk("br_stall",      32'(stall),      32'd0);
        cyc; branch = 1'b0; #1;
        chk("fl_flush",      32'(flush),      32'd1);
        chk("fl_load_arith", 32'(load_arith), 32'd0);
        chk("fl_incr",       32'(incr),       32'd1);
        cyc; #1;
        chk("flend_flush", 32'(flush), 32'd0);
        chk("flend_incr",  32'(incr),  32'd1);
        chk("flend_cnt",   32'(cnt),   32'd4);

        // Branch while waiting on memory; the late ack is dropped
        cyc; ack = 1'b0; #1;
        chk("wm_enter_stall", 32'(stall), 32'd1);
        cyc; branch = 1'b1; #1;
        chk("wmbr_load_arith", 32'(load_arith), 32'd1);
        chk("wmbr_stall",      32'(stall),      32'd0);
        cyc; branch = 1'b0; #1;
        chk("wmfl_flush", 32'(flush), 32'd1);
        chk("wmfl_incr",  32'(incr),  32'd0);
        cyc; ack = 1'b1; #1;
        chk("drop_incr",  32'(incr),  32'd0);
        chk("drop_stall", 32'(stall), 32'd1);
        cyc; #1;
        chk("after_drop_incr", 32'(incr), 32'd1);
        chk("after_drop_cnt",  32'(cnt),  32'd6);

        // Halt and load-use together: halt wins
        cyc; halt = 1'b1; load_use = 1'b1; #1;
        chk("hl_stall", 32'(stall), 32'd1);
        chk("hl_incr",  32'(incr),  32'd0);
        cyc; halt = 1'b0; load_use = 1'b0; branch = 1'b1; #1;
        chk("halt_halted",     32'(halted),     32'd1);
        chk("halt_req",        32'(imem_req),   32'd0);
        chk("halt_load_arith", 32'(load_arith), 32'd0);
        chk("halt_flush",      32'(flush),      32'd0);
        cyc; branch = 1'b0; resume = 1'b1; #1;
        chk("halt2_halted", 32'(halted), 32'd1);
        cyc; resume = 1'b0; #1;
        chk("resume_halted", 32'(halted),   32'd0);
        chk("resume_req",    32'(imem_req), 32'd1);
        chk("resume_incr",   32'(incr),     32'd1);
        chk("resume_cnt",    32'(cnt),      32'd9);

        // Long load-use stall: 4-bit counter saturates at 15
        cyc; load_use = 1'b1; #1;
        chk("lu_stall", 32'(stall), 32'd1);
        chk("lu_incr",  32'(incr),  32'd0);
        repeat (20) cyc;
        #1;
        chk("sat_cnt4", 32'(cnt4), 32'd15);
        chk("sat_cnt",  32'(cnt),  32'd29);
        load_use = 1'b0; ack = 1'b0; cnt_clr = 1'b1; #1;
        cyc; cnt_clr = 1'b0; ack = 1'b1; #1;
        chk("clr_cnt4", 32'(cnt4), 32'd0);
        chk("clr_cnt",  32'(cnt),  32'd0);
        chk("clr_incr", 32'(incr), 32'd1);

        // Reset in the middle of FLUSH
        cyc; branch = 1'b1; #1;
        cyc; branch = 1'b0; #1;
        chk("mf_flush", 32'(flush), 32'd1);
        rst = 1'b1; #1;
        chk("mf_rst_flush", 32'(flush),    32'd0);
        chk("mf_rst_stall", 32'(stall),    32'd1);
        chk("mf_rst_req",   32'(imem_req), 32'd0);
        cyc; rst = 1'b0; #1;
        chk("mf_boot_stall", 32'(stall), 32'd1);
        chk("mf_boot_flush", 32'(flush), 32'd0);
        cyc; #1;
        chk("mf_fetch_incr",  32'(incr),  32'd1);
        chk("mf_fetch_flush", 32'(flush), 32'd0);

        // Reset while a dropped ack is pending
        cyc; ack = 1'b0; #1;
        cyc; branch = 1'b1; #1;
        cyc; branch = 1'b0; #1;
        chk("mw_flush", 32'(flush), 32'd1);
        chk("mw_cnt",   32'(cnt),   32'd2);
        rst = 1'b1; #1;
        chk("mw_rst_cnt",   32'(cnt),   32'd0);
        chk("mw_rst_stall", 32'(stall), 32'd1);
        cyc; rst = 1'b0; ack = 1'b1; #1;
        chk("mw_boot_req", 32'(imem_req), 32'd0);
        cyc; #1;
        chk("mw_fetch_incr", 32'(incr), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
